// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the memory arbiter and its round-robin
// grant helper.
//   state_t  - arbiter FSM states (IDLE, ACCESS, RESP)
//   PORT_IF  - index of the instruction-fetch requester (bit 0 of req/gnt)
//   PORT_D   - index of the data requester (bit 1 of req/gnt)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant, purely combinational.
//   req  [1:0] in  - request vector, indexed by PORT_IF / PORT_D
//   last       in  - index of the port granted most recently
//   gnt  [1:0] out - one-hot grant (all zero when nothing is requested)
// A lone request is granted at once; on a tie the port that was not
// granted last time wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[PORT_IF] && req[PORT_D]) begin
      gnt = 2'b00;
      if (last == PORT_D) begin
        gnt[PORT_IF] = 1'b1;
      end else begin
        gnt[PORT_D] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch
// requester and a data requester using round-robin arbitration.
//   clk, reset                     - clock, asynchronous active-high reset
//   if_req, if_addr, if_ack        - fetch port (always a word read)
//   d_req, d_we, d_word, d_addr,
//   d_wdata, d_ack                 - data port (read/write, word/byte)
//   err, rdata                     - response, valid together with an ack
//   mem_addr, mem_wdata, mem_rdata,
//   mem_word, mem_wr_n             - memory side, driven only in ACCESS
// Aligned access: ack two cycles after the request is seen in IDLE.
// Misaligned word access (addr[0]=1): no memory cycle, ack one cycle
// after the request with err=1.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_word,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_word,
  output logic              mem_wr_n
);

  state_t state_reg;
  logic   port_reg;   // port owning the in-flight transaction
  logic   we_reg;     // latched write flag of the in-flight transaction
  logic   last_reg;   // most recently completed grant

  logic [1:0]        gnt;
  logic              sel_d;
  logic              any_gnt;
  logic              we_next;
  logic              word_next;
  logic              mis_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;

  rr_arb2 u_rr_arb2 (
    .req  ({d_req, if_req}),
    .last (last_reg),
    .gnt  (gnt)
  );

  // Qualifiers of the winning port; a fetch is always a word read.
  always_comb begin
    sel_d      = gnt[PORT_D];
    any_gnt    = |gnt;
    we_next    = sel_d & d_we;
    word_next  = sel_d ? d_word : 1'b1;
    addr_next  = sel_d ? d_addr : if_addr;
    wdata_next = sel_d ? d_wdata : '0;
    mis_next   = word_next & addr_next[0];
  end

  // The mem_* registers double as the latched addr/wdata/word of the
  // granted request; they hold those values only for the ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      port_reg  <= PORT_D;
      we_reg    <= 1'b0;
      last_reg  <= PORT_D;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_word  <= 1'b0;
      mem_wr_n  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_gnt) begin
            port_reg <= sel_d;
            we_reg   <= we_next;
            if (mis_next) begin
              // Skip the memory cycle and answer with an error.
              state_reg <= RESP;
              if_ack    <= ~sel_d;
              d_ack     <= sel_d;
              err       <= 1'b1;
              rdata     <= '0;
            end else begin
              state_reg <= ACCESS;
              mem_addr  <= addr_next;
              mem_wdata <= wdata_next;
              mem_word  <= word_next;
              mem_wr_n  <= ~we_next;
            end
          end
        end
        ACCESS: begin
          state_reg <= RESP;
          rdata     <= we_reg ? '0 : mem_rdata;
          err       <= 1'b0;
          if_ack    <= (port_reg == PORT_IF);
          d_ack     <= (port_reg == PORT_D);
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_word  <= 1'b0;
          mem_wr_n  <= 1'b1;
        end
        RESP: begin
          state_reg <= IDLE;
          if_ack    <= 1'b0;
          d_ack     <= 1'b0;
          err       <= 1'b0;
          rdata     <= '0;
          last_reg  <= port_reg;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Table of single-port transactions, hand-written tie and reset sequences,
// then randomized traffic on both ports checked against a transaction-level
// model (round-robin choice plus fixed service latencies).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic        d_word = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        if_ack, d_ack, err, mem_word, mem_wr_n;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        use_fn = 1'b0;
  logic [15:0] force_rd = '0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic        dword;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [15:0] mrd;
    logic        exp_d;
    int          exp_lat;
    logic        exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] exp_maddr;
    logic [15:0] exp_mwdata;
    logic        exp_mword;
    int          exp_wrlow;
  } vec_t;

  vec_t vecs[9];

  // transaction-level model state for the random phase
  int          cyc_free, ack_cyc, acc_cyc, last_p, ex_port;
  logic        ex_err, ex_we, ex_word;
  logic [15:0] ex_rdata, ex_addr, ex_wdata;
  logic        ip_pend, dp_pend, dp_we, dp_word;
  logic [15:0] ip_addr, dp_addr, dp_wdata;
  logic [12:0] ifpat, dpat;

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign mem_rdata = use_fn ? memf(mem_addr) : force_rd;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_word    (d_word),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_word  (mem_word),
    .mem_wr_n  (mem_wr_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int          lat;
    int          wrlow;
    int          acks;
    logic        gd, gerr, mword;
    logic [15:0] grd, maddr, mwdata;
    lat = -1; wrlow = 0; acks = 0;
    gd = 1'b0; gerr = 1'b0; mword = 1'b0;
    grd = '0; maddr = '0; mwdata = '0;
    use_fn = 1'b0;
    force_rd = v.mrd;
    @(posedge clk); #1;
    if_req = v.ireq;  if_addr = v.iaddr;
    d_req = v.dreq;   d_we = v.dwe; d_word = v.dword;
    d_addr = v.daddr; d_wdata = v.dwdata;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!mem_wr_n) wrlow++;
      if (k == 1) begin
        maddr = mem_addr; mwdata = mem_wdata; mword = mem_word;
      end
      if (if_ack || d_ack) begin
        acks++;
        if (lat < 0) begin
          lat = k; gd = d_ack; gerr = err; grd = rdata;
        end
        if_req = 1'b0;
        d_req = 1'b0;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    $display("vec %0d: port=%0d lat=%0d err=%0b rdata=0x%04h", idx, gd, lat, gerr, grd);
    chk("vec_latency", lat, v.exp_lat);
    chk("vec_port", 32'(gd), 32'(v.exp_d));
    chk("vec_err", 32'(gerr), 32'(v.exp_err));
    chk("vec_rdata", 32'(grd), 32'(v.exp_rdata));
    chk("vec_mem_addr", 32'(maddr), 32'(v.exp_maddr));
    chk("vec_mem_wdata", 32'(mwdata), 32'(v.exp_mwdata));
    chk("vec_mem_word", 32'(mword), 32'(v.exp_mword));
    chk("vec_wr_low_cycles", wrlow, v.exp_wrlow);
    chk("vec_ack_count", acks, 1);
  endtask

  task automatic seq_both();
    @(negedge clk);
    reset = 1'b1;
    use_fn = 1'b1;
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1;  d_we = 1'b0; d_word = 1'b1; d_addr = 16'h0200; d_wdata = '0;
    @(negedge clk);
    reset = 1'b0;
    ifpat = '0;
    dpat = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ifpat = ifpat | (13'(if_ack) << k);
      dpat = dpat | (13'(d_ack) << k);
      if (if_ack) chk("both_if_rdata", 32'(rdata), 32'(memf(16'h0100)));
      if (d_ack) chk("both_d_rdata", 32'(rdata), 32'(memf(16'h0200)));
      if (if_ack || d_ack) $display("both: cycle %0d if_ack=%0b d_ack=%0b rdata=0x%04h", k, if_ack, d_ack, rdata);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("both_if_ack_cycles", 32'(ifpat), 32'h104);
    chk("both_d_ack_cycles", 32'(dpat), 32'h820);
    repeat (2) @(negedge clk);
  endtask

  task automatic seq_reset_mid();
    apply_vec(99, vecs[0]);   // leaves fetch as the most recent grant
    use_fn = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_word = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access_wr_n", 32'(mem_wr_n), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_wr_n", 32'(mem_wr_n), 32'd1);
    chk("mid_reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_reset_mem_wdata", 32'(mem_wdata), 32'd0);
    if_req = 1'b1;
    if_addr = 16'h0300;
    @(negedge clk);
    chk("mid_reset_acks", 32'({if_ack, d_ack}), 32'd0);
    reset = 1'b0;
    ifpat = '0;
    dpat = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ifpat = ifpat | (13'(if_ack) << k);
      dpat = dpat | (13'(d_ack) << k);
      if (if_ack || d_ack) $display("after reset: cycle %0d if_ack=%0b d_ack=%0b", k, if_ack, d_ack);
      if (if_ack) if_req = 1'b0;
      if (d_ack) begin
        chk("mid_d_rdata", 32'(rdata), 32'd0);
        d_req = 1'b0;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("mid_if_ack_cycles", 32'(ifpat), 32'h004);
    chk("mid_d_ack_cycles", 32'(dpat), 32'h020);
    repeat (2) @(negedge clk);
  endtask

  task automatic random_phase();
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    use_fn = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc_free = 0; ack_cyc = -10; acc_cyc = -10; last_p = 1; ex_port = 0;
    ip_pend = 1'b0; dp_pend = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      // a requester drops its transaction the cycle after its ack
      if (c - 1 == ack_cyc) begin
        if (ex_port == 0) ip_pend = 1'b0;
        else dp_pend = 1'b0;
      end
      if (!ip_pend && $urandom_range(0, 2) != 0) begin
        ip_pend = 1'b1;
        ip_addr = 16'($urandom);
      end
      if (!dp_pend && $urandom_range(0, 2) != 0) begin
        dp_pend = 1'b1;
        dp_we = 1'($urandom);
        dp_word = 1'($urandom);
        dp_addr = 16'($urandom);
        dp_wdata = 16'($urandom);
      end
      if_req = ip_pend;
      if_addr = ip_pend ? ip_addr : 16'($urandom);
      d_req = dp_pend;
      d_we = dp_pend ? dp_we : 1'($urandom);
      d_word = dp_pend ? dp_word : 1'($urandom);
      d_addr = dp_pend ? dp_addr : 16'($urandom);
      d_wdata = dp_pend ? dp_wdata : 16'($urandom);
      // arbiter free and someone waiting: decide winner and schedule
      if (c >= cyc_free && (ip_pend || dp_pend)) begin
        if (ip_pend && dp_pend) ex_port = (last_p == 1) ? 0 : 1;
        else ex_port = dp_pend ? 1 : 0;
        if (ex_port == 0) begin
          ex_addr = ip_addr; ex_we = 1'b0; ex_word = 1'b1; ex_wdata = '0;
        end else begin
          ex_addr = dp_addr; ex_we = dp_we; ex_word = dp_word; ex_wdata = dp_wdata;
        end
        ex_err = ex_word & ex_addr[0];
        ex_rdata = (ex_err || ex_we) ? 16'h0 : memf(ex_addr);
        ack_cyc = c + (ex_err ? 1 : 2);
        acc_cyc = ex_err ? -10 : c + 1;
        cyc_free = ack_cyc + 1;
        last_p = ex_port;
      end
      @(negedge clk);
      chk("rnd_if_ack", 32'(if_ack), 32'(c == ack_cyc && ex_port == 0));
      chk("rnd_d_ack", 32'(d_ack), 32'(c == ack_cyc && ex_port == 1));
      if (c == ack_cyc) begin
        $display("rnd txn: cycle %0d port=%0d addr=0x%04h we=%0b word=%0b err=%0b rdata=0x%04h",
                 c, ex_port, ex_addr, ex_we, ex_word, err, rdata);
        chk("rnd_err", 32'(err), 32'(ex_err));
        chk("rnd_rdata", 32'(rdata), 32'(ex_rdata));
      end
      if (c == acc_cyc) begin
        chk("rnd_mem_addr", 32'(mem_addr), 32'(ex_addr));
        chk("rnd_mem_word", 32'(mem_word), 32'(ex_word));
        chk("rnd_mem_wr_n", 32'(mem_wr_n), 32'(!ex_we));
        if (ex_we) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(ex_wdata));
      end else begin
        chk("rnd_idle_mem_addr", 32'(mem_addr), 32'd0);
        chk("rnd_idle_wr_n_word", 32'({mem_wr_n, mem_word}), 32'h2);
        chk("rnd_idle_mem_wdata", 32'(mem_wdata), 32'd0);
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{ireq:1'b1, iaddr:16'h0010, dreq:1'b0, dwe:1'b1, dword:1'b0, daddr:16'hAAAA, dwdata:16'h0,
                mrd:16'h1234, exp_d:1'b0, exp_lat:2, exp_err:1'b0, exp_rdata:16'h1234,
                exp_maddr:16'h0010, exp_mwdata:16'h0, exp_mword:1'b1, exp_wrlow:0};
    vecs[1] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b1, dword:1'b0, daddr:16'h0021, dwdata:16'h00AB,
                mrd:16'hFFFF, exp_d:1'b1, exp_lat:2, exp_err:1'b0, exp_rdata:16'h0,
                exp_maddr:16'h0021, exp_mwdata:16'h00AB, exp_mword:1'b0, exp_wrlow:1};
    vecs[2] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b0, dword:1'b1, daddr:16'h0003, dwdata:16'h0,
                mrd:16'h7777, exp_d:1'b1, exp_lat:1, exp_err:1'b1, exp_rdata:16'h0,
                exp_maddr:16'h0, exp_mwdata:16'h0, exp_mword:1'b0, exp_wrlow:0};
    vecs[3] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b0, dword:1'b1, daddr:16'h0100, dwdata:16'h0,
                mrd:16'hBEEF, exp_d:1'b1, exp_lat:2, exp_err:1'b0, exp_rdata:16'hBEEF,
                exp_maddr:16'h0100, exp_mwdata:16'h0, exp_mword:1'b1, exp_wrlow:0};
    vecs[4] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b0, dword:1'b0, daddr:16'h0055, dwdata:16'h0,
                mrd:16'h00C3, exp_d:1'b1, exp_lat:2, exp_err:1'b0, exp_rdata:16'h00C3,
                exp_maddr:16'h0055, exp_mwdata:16'h0, exp_mword:1'b0, exp_wrlow:0};
    vecs[5] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b1, dword:1'b1, daddr:16'h0202, dwdata:16'h5A5A,
                mrd:16'h1111, exp_d:1'b1, exp_lat:2, exp_err:1'b0, exp_rdata:16'h0,
                exp_maddr:16'h0202, exp_mwdata:16'h5A5A, exp_mword:1'b1, exp_wrlow:1};
    vecs[6] = '{ireq:1'b1, iaddr:16'h0011, dreq:1'b0, dwe:1'b1, dword:1'b1, daddr:16'h0000, dwdata:16'h0,
                mrd:16'h2222, exp_d:1'b0, exp_lat:1, exp_err:1'b1, exp_rdata:16'h0,
                exp_maddr:16'h0, exp_mwdata:16'h0, exp_mword:1'b0, exp_wrlow:0};
    vecs[7] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b1, dword:1'b1, daddr:16'hFFFF, dwdata:16'h3333,
                mrd:16'h4444, exp_d:1'b1, exp_lat:1, exp_err:1'b1, exp_rdata:16'h0,
                exp_maddr:16'h0, exp_mwdata:16'h0, exp_mword:1'b0, exp_wrlow:0};
    vecs[8] = '{ireq:1'b0, iaddr:16'h0000, dreq:1'b1, dwe:1'b1, dword:1'b0, daddr:16'hFFFF, dwdata:16'h00FE,
                mrd:16'h5555, exp_d:1'b1, exp_lat:2, exp_err:1'b0, exp_rdata:16'h0,
                exp_maddr:16'hFFFF, exp_mwdata:16'h00FE, exp_mword:1'b0, exp_wrlow:1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_if_ack", 32'(if_ack), 32'd0);
    chk("reset_d_ack", 32'(d_ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_mem_wr_n", 32'(mem_wr_n), 32'd1);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_mem_word", 32'(mem_word), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);
    seq_both();
    seq_reset_mid();
    random_phase();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning memory data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port if_req, input, 1, instruction-fetch read request (always word).
REQ-006 The block SHALL have port if_addr, input, ADDR_W, fetch byte address.
REQ-007 The block SHALL have port if_ack, output, 1, one-cycle fetch completion pulse.
REQ-008 The block SHALL have port d_req, input, 1, data-port request.
REQ-009 The block SHALL have port d_we, input, 1, data write when 1, read when 0.
REQ-010 The block SHALL have port d_word, input, 1, word access when 1, byte access when 0.
REQ-011 The block SHALL have ports d_addr (input, ADDR_W, byte address) and d_wdata (input, DATA_W, write data).
REQ-012 The block SHALL have port d_ack, output, 1, one-cycle data completion pulse.
REQ-013 The block SHALL have port err, output, 1, misaligned-access flag, valid with either ack.
REQ-014 The block SHALL have port rdata, output, DATA_W, read data, valid with either ack.
REQ-015 The block SHALL have memory ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W), mem_word (output, 1, word/byte lane select, 1 = word).
REQ-016 The block SHALL have port mem_wr_n, output, 1, active-low memory write strobe.

Function
REQ-017 The block SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 IDLE: with no request, remain in IDLE; with one or both requests, grant one port, latch its addr/wdata/we/word into internal registers.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted most recently; single request is granted immediately.
REQ-020 Fetch grant SHALL latch we=0, word=1 regardless of d_* inputs.
REQ-021 A granted word access with addr[0]=1 SHALL be misaligned: go IDLE->RESP directly, no memory cycle, err=1, rdata=0.
REQ-022 Aligned grant SHALL go IDLE->ACCESS; in ACCESS drive latched addr/wdata/word onto mem_*; mem_wr_n=0 only if we=1.
REQ-023 At the rising edge ending ACCESS, rdata SHALL capture mem_rdata unchanged (reads) or 0 (writes); go RESP.
REQ-024 RESP: assert exactly one of if_ack/d_ack for the granted port for one cycle, err per REQ-021 else 0; update last-grant pointer; go IDLE.
REQ-025 Latency SHALL be: request present in IDLE cycle N -> ack in cycle N+2 (aligned) or N+1 (misaligned).
REQ-026 Outside ACCESS: mem_wr_n=1, mem_addr=0, mem_wdata=0, mem_word=0.
REQ-027 Requester SHALL hold req and qualifiers until ack; req still high in the cycle after ack is a new request.
REQ-028 Input changes during ACCESS/RESP SHALL NOT affect the in-flight transaction.
REQ-029 Byte accesses SHALL pass address unchanged; lane selection and sign extension belong to memory.

Reset
REQ-030 Reset SHALL immediately force state IDLE, mem_wr_n=1, mem_addr/mem_wdata/mem_word=0, if_ack=d_ack=0, err=0, rdata=0, last-grant pointer = data (fetch wins first tie).
REQ-031 Reset asserted during ACCESS SHALL abort the access with no ack after release.

Structure
REQ-032 State enum, port index constants (PORT_IF=0, PORT_D=1) SHALL reside in shared package mem_pkg.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arb2 (two requests, last-grant in, one-hot grant out).

Verification
REQ-034 Fetch read 0x0010, mem_rdata=0x1234 -> mem_addr=0x0010, mem_word=1, mem_wr_n=1 in ACCESS; if_ack with rdata=0x1234 two cycles after req.
REQ-035 Data byte write addr 0x0021 wdata 0x00AB -> one ACCESS cycle mem_wr_n=0, mem_word=0, mem_addr=0x0021; d_ack, err=0, rdata=0.
REQ-036 Both req held high continuously from reset -> grants alternate IF, D, IF, D; acks every third cycle.
REQ-037 Data word read addr 0x0003 -> d_ack one cycle after req, err=1, mem_wr_n never low, mem_addr stays 0.
REQ-038 Reset asserted mid-ACCESS of a write -> mem_wr_n=1 at once, no ack; next request after release serves fetch first on tie.
